lb_stream_writer: RTL and testbench

- Streaming stage directly downstream of the collision datapath.
- Accepts one post-collision node (nine 14-bit populations plus node x,y) per handshake.
- Scatters each population into the neighbouring node of the inactive RAM, one 16-bit write per cycle.
- Applies half-way bounce-back at lattice edges; signals end of sweep so the controller can swap active_ram.

---
 rtl/lb_stream_writer_if.sv | 45 ++++
 rtl/lb_stream_writer.sv | 183 ++++++++++++++++++
 tb/tb_lb_stream_writer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lb_stream_writer_if.sv
// Node-in / RAM-write bundle for the lattice Boltzmann stream writer.
// Shared by builds with and without LB_PERIODIC_X_EN.
interface lb_stream_writer_if #(
  parameter int COORD_BITS = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [COORD_BITS-1:0] in_x;
  logic [COORD_BITS-1:0] in_y;
  logic [125:0]          in_f;
  logic                  in_last;
  logic [14:0]           ram_addr;
  logic [15:0]           ram_dout;
  logic                  ram_en;
  logic                  ram_wen;
  logic                  ram_sel;

  modport master (
    output in_valid,
    output in_x,
    output in_y,
    output in_f,
    output in_last,
    input  in_ready,
    input  ram_addr,
    input  ram_dout,
    input  ram_en,
    input  ram_wen,
    input  ram_sel
  );

  modport slave (
    input  in_valid,
    input  in_x,
    input  in_y,
    input  in_f,
    input  in_last,
    output in_ready,
    output ram_addr,
    output ram_dout,
    output ram_en,
    output ram_wen,
    output ram_sel
  );
endinterface

// File: rtl/lb_stream_writer.sv
// LBM streaming stage: scatters nine populations per node into the inactive RAM.
// Define LB_PERIODIC_X_EN for wrap-around in x; default bounces back on all edges.
module lb_stream_writer #(
  parameter int LATTICE_WIDTH  = 16,
  parameter int LATTICE_HEIGHT = 10,
  parameter int COORD_BITS     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active_ram,
  lb_stream_writer_if.slave  bus,
  output logic               sweep_done,
  output logic               err_oob
);

  typedef enum logic {
    IDLE,
    WRITE
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            dir_q, dir_d;
  logic [COORD_BITS-1:0] x_q, x_d;
  logic [COORD_BITS-1:0] y_q, y_d;
  logic [125:0]          f_q, f_d;
  logic                  last_q, last_d;
  logic                  sel_q, sel_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic acc_slot;
  logic hs;
  logic oob;
  int   in_xi;
  int   in_yi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      f_q     <= '0;
      last_q  <= 1'b0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      f_q     <= f_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // A new node can be taken when idle or during the final write of the current one.
  assign acc_slot = (state_q == IDLE) ||
                    ((state_q == WRITE) && (dir_q == 4'd8));
  assign bus.in_ready = acc_slot & ~reset;
  assign hs = bus.in_valid & bus.in_ready;

  assign in_xi = int'(bus.in_x);
  assign in_yi = int'(bus.in_y);
  assign oob = (in_xi >= LATTICE_WIDTH) || (in_yi >= LATTICE_HEIGHT);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    f_d     = f_q;
    last_d  = last_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      WRITE: begin
        if (dir_q == 4'd8) begin
          done_d  = last_q;
          state_d = IDLE;
        end else begin
          dir_d = dir_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (hs) begin
      if (oob) begin
        err_d   = 1'b1;
        state_d = IDLE;
        done_d  = done_d | bus.in_last;
      end else begin
        state_d = WRITE;
        dir_d   = 4'd0;
        x_d     = bus.in_x;
        y_d     = bus.in_y;
        f_d     = bus.in_f;
        last_d  = bus.in_last;
        sel_d   = ~active_ram;
      end
    end
  end

  int         dx, dy;
  int         xs, ys;
  int         nx, ny;
  int         node;
  int         addr_i;
  logic       x_out, y_out;
  logic [3:0] opp;
  logic [3:0] wdir;
  logic [13:0] fd;

  always_comb begin
    dx  = 0;
    dy  = 0;
    opp = 4'd0;
    case (dir_q)
      4'd1: begin dy = 1;           opp = 4'd5; end
      4'd2: begin dx = 1;  dy = 1;  opp = 4'd6; end
      4'd3: begin dx = 1;           opp = 4'd7; end
      4'd4: begin dx = 1;  dy = -1; opp = 4'd8; end
      4'd5: begin dy = -1;          opp = 4'd1; end
      4'd6: begin dx = -1; dy = -1; opp = 4'd2; end
      4'd7: begin dx = -1;          opp = 4'd3; end
      4'd8: begin dx = -1; dy = 1;  opp = 4'd4; end
      default: begin dx = 0; dy = 0; opp = 4'd0; end
    endcase

    xs    = int'(x_q);
    ys    = int'(y_q);
    nx    = xs + dx;
    ny    = ys + dy;
    x_out = (nx < 0) || (nx >= LATTICE_WIDTH);
    y_out = (ny < 0) || (ny >= LATTICE_HEIGHT);

`ifdef LB_PERIODIC_X_EN
    // y-edges take priority: a diagonal off a y-edge still bounces back.
    if (x_out && !y_out) begin
      nx    = (nx < 0) ? nx + LATTICE_WIDTH : nx - LATTICE_WIDTH;
      x_out = 1'b0;
    end
`endif

    if (x_out || y_out) begin
      node = ys * LATTICE_WIDTH + xs;
      wdir = opp;
    end else begin
      node = ny * LATTICE_WIDTH + nx;
      wdir = dir_q;
    end
    addr_i = node * 9 + int'(wdir);
    fd     = f_q[14*dir_q +: 14];
  end

  always_comb begin
    bus.ram_en   = 1'b0;
    bus.ram_wen  = 1'b0;
    bus.ram_addr = '0;
    bus.ram_dout = '0;
    bus.ram_sel  = sel_q;
    if (state_q == WRITE) begin
      bus.ram_en   = 1'b1;
      bus.ram_wen  = 1'b1;
      bus.ram_addr = addr_i[14:0];
      bus.ram_dout = {{2{fd[13]}}, fd};
    end
  end

  assign sweep_done = done_q;
  assign err_oob    = err_q;

endmodule

// File: tb/tb_lb_stream_writer.sv
// Directed bench for lb_stream_writer with a write scoreboard.
// Expectations follow LB_PERIODIC_X_EN when the build defines it.
module tb_lb_stream_writer;
  localparam int W = 16;
  localparam int H = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic active_ram = 1'b0;
  logic sweep_done;
  logic err_oob;

  always #5 clk = ~clk;

  lb_stream_writer_if #(.COORD_BITS(8)) bus ();

  lb_stream_writer #(
    .LATTICE_WIDTH (W),
    .LATTICE_HEIGHT(H),
    .COORD_BITS    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .active_ram(active_ram),
    .bus       (bus),
    .sweep_done(sweep_done),
    .err_oob   (err_oob)
  );

  typedef struct packed {
    logic [14:0] a;
    logic [15:0] d;
    logic        s;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  nwr = 0;

  int dx_t[9]  = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
  int dy_t[9]  = '{0, 1, 1, 0, -1, -1, -1, 0, 1};
  int opp_t[9] = '{0, 5, 6, 7, 8, 1, 2, 3, 4};

`ifdef LB_PERIODIC_X_EN
  localparam int W_ADDR_03 = 574;
`else
  localparam int W_ADDR_03 = 435;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic wr_t model(input int x, input int y, input int d,
                                input logic [13:0] v, input logic s);
    wr_t r;
    int  nx, ny, a;
    bit  xo, yo;
    nx = x + dx_t[d];
    ny = y + dy_t[d];
    xo = (nx < 0) || (nx >= W);
    yo = (ny < 0) || (ny >= H);
`ifdef LB_PERIODIC_X_EN
    if (xo && !yo) begin
      nx = (nx + W) % W;
      xo = 1'b0;
    end
`endif
    if (xo || yo) a = (y * W + x) * 9 + opp_t[d];
    else          a = (ny * W + nx) * 9 + d;
    r.a = a[14:0];
    r.d = {{2{v[13]}}, v};
    r.s = s;
    return r;
  endfunction

  task automatic push_node(input int x, input int y,
                           input logic [125:0] f, input logic s);
    for (int d = 0; d < 9; d++)
      exp_q.push_back(model(x, y, d, f[14*d +: 14], s));
  endtask

  task automatic cyc();
    wr_t e;
    @(posedge clk);
    #1;
    if (bus.ram_wen === 1'b1) begin
      nwr++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", bus.ram_wen, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ram_addr", bus.ram_addr, e.a);
        chk("ram_dout", bus.ram_dout, e.d);
        chk("ram_sel", bus.ram_sel, e.s);
        chk("ram_en", bus.ram_en, 1);
      end
    end
  endtask

  function automatic logic [125:0] rand_f();
    logic [125:0] f;
    for (int d = 0; d < 9; d++) f[14*d +: 14] = 14'($urandom);
    return f;
  endfunction

  logic [125:0] fseq;
  logic [125:0] fa, fb;
  int int_addr[9] = '{765, 910, 920, 777, 634, 626, 618, 763, 908};

  initial begin
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.in_y     = '0;
    bus.in_f     = '0;
    bus.in_last  = 1'b0;
    for (int d = 0; d < 9; d++) fseq[14*d +: 14] = 14'(d + 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_wen", bus.ram_wen, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_dout", bus.ram_dout, 0);
    chk("rst_ram_sel", bus.ram_sel, 0);
    chk("rst_sweep_done", sweep_done, 0);
    chk("rst_err_oob", err_oob, 0);
    reset = 1'b0;
    cyc();
    chk("post_rst_ready", bus.in_ready, 1);

    // interior node (5,5)
    active_ram = 1'b0;
    for (int d = 0; d < 9; d++)
      exp_q.push_back('{a: 15'(int_addr[d]), d: 16'(d + 1), s: 1'b1});
    bus.in_x = 8'd5; bus.in_y = 8'd5; bus.in_f = fseq;
    bus.in_last = 1'b0; bus.in_valid = 1'b1;
    nwr = 0;
    cyc();
    bus.in_valid = 1'b0;
    repeat (8) cyc();
    cyc();
    chk("interior_writes", nwr, 9);
    chk("interior_idle_ready", bus.in_ready, 1);

    // corner (0,0)
    push_node(0, 0, fseq, 1'b1);
    bus.in_x = 8'd0; bus.in_y = 8'd0; bus.in_valid = 1'b1;
    nwr = 0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      bus.in_valid = 1'b0;
      if (i == 6) chk("corner_sw_addr", bus.ram_addr, 2);
      if (i == 1) chk("corner_n_addr", bus.ram_addr, 145);
    end
    cyc();
    chk("corner_writes", nwr, 9);

    // back-to-back, second node last
    active_ram = 1'b1;
    fa = rand_f();
    fb = rand_f();
    fa[13:0] = 14'h2abc;
    push_node(3, 2, fa, 1'b0);
    push_node(15, 9, fb, 1'b0);
    bus.in_x = 8'd3; bus.in_y = 8'd2; bus.in_f = fa;
    bus.in_last = 1'b0; bus.in_valid = 1'b1;
    chk("b2b_first_ready", bus.in_ready, 1);
    nwr = 0;
    for (int i = 0; i < 18; i++) begin
      cyc();
      chk("b2b_ready", bus.in_ready, (i == 8 || i == 17) ? 1 : 0);
      chk("b2b_no_done", sweep_done, 0);
      chk("b2b_wen", bus.ram_wen, 1);
      if (i == 0) begin
        bus.in_x = 8'd15; bus.in_y = 8'd9; bus.in_f = fb;
        bus.in_last = 1'b1;
      end
      if (i == 9) begin
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
      end
    end
    cyc();
    chk("b2b_done_pulse", sweep_done, 1);
    chk("b2b_idle_wen", bus.ram_wen, 0);
    cyc();
    chk("b2b_done_single", sweep_done, 0);
    chk("b2b_writes", nwr, 18);

    // out-of-range nodes are dropped
    active_ram = 1'b0;
    bus.in_x = 8'd20; bus.in_y = 8'd3; bus.in_f = rand_f();
    bus.in_last = 1'b1; bus.in_valid = 1'b1;
    nwr = 0;
    cyc();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("oob_err", err_oob, 1);
    chk("oob_done", sweep_done, 1);
    chk("oob_no_write", bus.ram_wen, 0);
    chk("oob_ready", bus.in_ready, 1);
    cyc();
    chk("oob_done_once", sweep_done, 0);
    bus.in_x = 8'd3; bus.in_y = 8'd10; bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("oob_sticky", err_oob, 1);
    chk("oob_no_done", sweep_done, 0);
    chk("oob_writes", nwr, 0);

    // west edge at (0,3)
    fa = rand_f();
    push_node(0, 3, fa, 1'b1);
    bus.in_x = 8'd0; bus.in_y = 8'd3; bus.in_f = fa; bus.in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      bus.in_valid = 1'b0;
      if (i == 7) chk("w_edge_addr", bus.ram_addr, W_ADDR_03);
    end
    cyc();
    chk("edge_err_sticky", err_oob, 1);

    // reset in the dir=4 cycle
    fa = rand_f();
    push_node(7, 4, fa, 1'b1);
    bus.in_x = 8'd7; bus.in_y = 8'd4; bus.in_f = fa; bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    repeat (4) cyc();
    reset = 1'b1;
    cyc();
    exp_q.delete();
    chk("mid_rst_wen", bus.ram_wen, 0);
    chk("mid_rst_en", bus.ram_en, 0);
    chk("mid_rst_addr", bus.ram_addr, 0);
    chk("mid_rst_dout", bus.ram_dout, 0);
    chk("mid_rst_sel", bus.ram_sel, 0);
    chk("mid_rst_done", sweep_done, 0);
    chk("mid_rst_err", err_oob, 0);
    chk("mid_rst_ready", bus.in_ready, 0);
    reset = 1'b0;
    cyc();
    chk("after_rst_ready", bus.in_ready, 1);
    chk("after_rst_wen", bus.ram_wen, 0);

    // far corner after reset
    active_ram = 1'b1;
    fa = rand_f();
    push_node(15, 9, fa, 1'b0);
    bus.in_x = 8'd15; bus.in_y = 8'd9; bus.in_f = fa;
    bus.in_last = 1'b1; bus.in_valid = 1'b1;
    nwr = 0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
    end
    cyc();
    chk("far_done", sweep_done, 1);
    chk("far_writes", nwr, 9);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
